// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: time-slices N_DIG digits, blanks the
// start of each slot against ghosting, and PWM-dims the rest in 16 steps.
module seg_scan_ctrl #(
    parameter int N_DIG     = 4,
    parameter int SCAN_CYC  = 12500,
    parameter int BLANK_CYC = 500
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(N_DIG)-1:0] wr_idx,
    input  logic [7:0]               wr_data,
    input  logic [3:0]               bright,
    output logic [7:0]               abcdefgh,
    output logic [N_DIG-1:0]         digit,
    output logic                     frame_start
);

    localparam int IDX_W   = $clog2(N_DIG);
    localparam int CNT_W   = $clog2(SCAN_CYC);
    localparam int SUB_CYC = (SCAN_CYC - BLANK_CYC) / 16;
    localparam int POS_W   = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIG - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(SUB_CYC - 1);
    localparam logic [IDX_W:0]   IDX_LIMIT = (IDX_W + 1)'(N_DIG);

    typedef enum logic [1:0] {BLANK, ON, OFF} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] slot_nxt;
    logic [IDX_W-1:0] idx;
    logic [3:0]       bright_lat;
    logic [3:0]       bright_eff;
    logic [3:0]       sub;
    logic [POS_W-1:0] sub_pos;
    logic             slot_wrap;
    logic             frame_edge;
    logic [7:0]       seg_nxt;
    logic [N_DIG-1:0] digit_nxt;
    logic [7:0]       shadow [N_DIG];
    logic [7:0]       disp   [N_DIG];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state is decided for the cycle holding slot_nxt; bright_eff lets the
    // brightness sampled this very cycle govern the slot that is just starting.
    always_comb begin
        slot_wrap  = (slot_cnt == CNT_LAST);
        slot_nxt   = slot_wrap ? '0 : slot_cnt + 1'b1;
        frame_edge = (slot_cnt == '0) && (idx == '0);
        bright_eff = (slot_cnt == '0) ? bright : bright_lat;
        state_nxt  = state;
        seg_nxt    = 8'hFF;
        digit_nxt  = '1;
        if (slot_nxt < CNT_BLANK) begin
            state_nxt = BLANK;
        end else if (slot_nxt == CNT_BLANK) begin
            state_nxt = ON;
        end else if (state == ON && sub_pos == POS_LAST && sub == bright_eff) begin
            state_nxt = OFF;
        end
        if (state == ON) begin
            seg_nxt        = ~disp[idx];
            digit_nxt[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt   <= '0;
            idx        <= '0;
            bright_lat <= '0;
            sub        <= '0;
            sub_pos    <= '0;
        end else begin
            slot_cnt <= slot_nxt;
            if (slot_wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (slot_cnt == '0) begin
                bright_lat <= bright;
            end
            // Sub-slot position restarts exactly where the active window opens.
            if (slot_nxt == CNT_BLANK) begin
                sub     <= '0;
                sub_pos <= '0;
            end else if (sub_pos == POS_LAST) begin
                sub     <= sub + 1'b1;
                sub_pos <= '0;
            end else begin
                sub_pos <= sub_pos + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_DIG; i++) begin
                shadow[i] <= '0;
                disp[i]   <= '0;
            end
        end else begin
            if (wr_en && ({1'b0, wr_idx} < IDX_LIMIT)) begin
                shadow[wr_idx] <= wr_data;
            end
            if (frame_edge) begin
                for (int i = 0; i < N_DIG; i++) begin
                    disp[i] <= shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abcdefgh    <= 8'hFF;
            digit       <= '1;
            frame_start <= 1'b0;
        end else begin
            abcdefgh    <= seg_nxt;
            digit       <= digit_nxt;
            frame_start <= frame_edge;
        end
    end

endmodule
